accum_result_packer: RTL

- Stage directly downstream of the last accumulator stage in the SpMV merge pipeline.
- Pops final {row_idx, value, valid} entries from the accumulator output FIFO and drops invalid entries.
- Packs valid entries into PACK_N-slot lines for the result writer, flushes a final partial line on data_ended, and flags row-order violations.

---
 rtl/spmv_pkg.sv | 37 +++
 rtl/pack_line_buf.sv | 61 ++++++
 rtl/accum_result_packer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/spmv_pkg.sv
// Shared types and default widths for the SpMV merge pipeline back end.
// The width constants stand in for the pipeline-wide defines and give
// the default parameter values of the blocks that import this package.
package spmv_pkg;

    localparam int SPMV_BITS_ROW_IDX   = 16;
    localparam int SPMV_DATA_PRECISION = 32;
    localparam int SPMV_DATA_WIDTH     = SPMV_BITS_ROW_IDX + SPMV_DATA_PRECISION + 1;
    localparam int SPMV_PACK_N         = 4;
    localparam int SPMV_BITS_PACK      = 2;
    localparam int SPMV_BITS_CNT       = 32;

    // One packed slot {row_idx, value} and one full output line.
    localparam int SPMV_SLOT_W = SPMV_BITS_ROW_IDX + SPMV_DATA_PRECISION;
    localparam int SPMV_LINE_W = SPMV_PACK_N * SPMV_SLOT_W;

    // Accumulator output FIFO entry; valid sits at bit 0.
    typedef struct packed {
        logic [SPMV_BITS_ROW_IDX-1:0]   row_idx;
        logic [SPMV_DATA_PRECISION-1:0] value;
        logic                           valid;
    } entry_t;

    // One slot of a packed line; row_idx occupies the MSBs.
    typedef struct packed {
        logic [SPMV_BITS_ROW_IDX-1:0]   row_idx;
        logic [SPMV_DATA_PRECISION-1:0] value;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } packer_state_e;

endpackage

// File: rtl/pack_line_buf.sv
// Slot array for one output line: writes land at the current fill index,
// the mask tracks occupied slots, and a clear empties the whole line.
module pack_line_buf #(
    parameter int SLOT_W    = 48,
    parameter int PACK_N    = 4,
    parameter int BITS_PACK = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [SLOT_W-1:0]        wr_data_i,
    input  logic                     clr_i,
    output logic [BITS_PACK:0]       fill_cnt_o,
    output logic [PACK_N*SLOT_W-1:0] line_data_o,
    output logic [PACK_N-1:0]        line_mask_o
);

    localparam logic [BITS_PACK:0] FULL = (BITS_PACK+1)'(PACK_N);

    logic [PACK_N-1:0][SLOT_W-1:0] slots_q, slots_d;
    logic [PACK_N-1:0]             mask_q, mask_d;
    logic [BITS_PACK:0]            fill_q, fill_d;
    logic [BITS_PACK-1:0]          wr_idx;

    assign wr_idx = fill_q[BITS_PACK-1:0];

    // Clear wins over write; a write into a full line is ignored.
    always_comb begin
        slots_d = slots_q;
        mask_d  = mask_q;
        fill_d  = fill_q;
        if (clr_i) begin
            slots_d = '0;
            mask_d  = '0;
            fill_d  = '0;
        end else if (wr_en_i && (fill_q < FULL)) begin
            slots_d[wr_idx] = wr_data_i;
            mask_d[wr_idx]  = 1'b1;
            fill_d          = fill_q + (BITS_PACK+1)'(1);
        end
    end

    // Slot, mask and fill registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            slots_q <= '0;
            mask_q  <= '0;
            fill_q  <= '0;
        end else begin
            slots_q <= slots_d;
            mask_q  <= mask_d;
            fill_q  <= fill_d;
        end
    end

    // Slot 0 lands in the LSBs of the flattened line.
    assign line_data_o = slots_q;
    assign line_mask_o = mask_q;
    assign fill_cnt_o  = fill_q;

endmodule

// File: rtl/accum_result_packer.sv
// Packs final accumulator entries into PACK_N-slot lines for the result
// writer. Invalid entries are dropped, a partial last line is flushed once
// the stream has ended and the FIFO is drained, and non-increasing row
// indices raise a sticky order error.
//
// Handshakes: upstream is a 1-cycle-latency FIFO read (di is valid the
// cycle after in_rd_en=1, so a read in flight is always captured);
// downstream is valid/ready, a line transfers on a cycle with
// line_valid=1 and line_ready=1, and line_data/line_mask/line_last hold
// steady while line_valid=1 and line_ready=0.
// state_dbg exposes the FSM state (IDLE=0, FILL=1, EMIT=2, DONE=3).
module accum_result_packer
    import spmv_pkg::*;
#(
    parameter int DATA_WIDTH     = SPMV_DATA_WIDTH,
    parameter int BITS_ROW_IDX   = SPMV_BITS_ROW_IDX,
    parameter int DATA_PRECISION = SPMV_DATA_PRECISION,
    parameter int PACK_N         = SPMV_PACK_N,
    parameter int BITS_PACK      = SPMV_BITS_PACK,
    parameter int BITS_CNT       = SPMV_BITS_CNT
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          en_global,
    input  logic                                          data_ended,
    input  logic                                          in_rd_ready,
    output logic                                          in_rd_en,
    input  logic [DATA_WIDTH-1:0]                         di,
    input  logic                                          line_ready,
    output logic                                          line_valid,
    output logic [PACK_N*(BITS_ROW_IDX+DATA_PRECISION)-1:0] line_data,
    output logic [PACK_N-1:0]                             line_mask,
    output logic                                          line_last,
    output logic [BITS_CNT-1:0]                           entry_cnt,
    output logic                                          err_order,
    output logic                                          done,
    output logic [1:0]                                    state_dbg
);

    localparam int E = BITS_ROW_IDX + DATA_PRECISION;
    localparam logic [BITS_PACK:0] PACK_FULL = (BITS_PACK+1)'(PACK_N);
    localparam logic [BITS_PACK:0] PACK_LAST = (BITS_PACK+1)'(PACK_N - 1);

    packer_state_e           state_q, state_d;
    logic                    pending_q, pending_d;
    logic                    ended_seen_q, ended_seen_d;
    logic [BITS_ROW_IDX-1:0] prev_row_q, prev_row_d;
    logic                    prev_valid_q, prev_valid_d;
    logic [BITS_CNT-1:0]     entry_cnt_q, entry_cnt_d;
    logic                    err_order_q, err_order_d;
    logic                    line_valid_q, line_valid_d;
    logic                    line_last_q, line_last_d;
    logic                    done_q, done_d;

    logic [BITS_PACK:0]      fill_cnt;
    logic                    rd_en;
    logic                    capture;
    logic                    handshake;
    logic                    line_full;
    logic                    flush;
    logic [BITS_ROW_IDX-1:0] in_row;
    logic [E-1:0]            in_slot;

    assign in_row  = di[DATA_WIDTH-1 -: BITS_ROW_IDX];
    assign in_slot = di[DATA_WIDTH-1:1];

    // A valid entry arriving from a read issued last cycle.
    assign capture   = pending_q && di[0];
    assign handshake = (state_q == EMIT) && line_valid_q && line_ready;

    // Reads are limited so that slots already claimed by an in-flight read
    // are never over-committed.
    assign rd_en = en_global && in_rd_ready && (state_q == FILL) &&
                   ((fill_cnt + {{BITS_PACK{1'b0}}, pending_q}) < PACK_FULL);

    // Full includes the cycle in which the last slot is being written.
    assign line_full = (fill_cnt == PACK_FULL) ||
                       (capture && (fill_cnt == PACK_LAST));

    // A pending read blocks the flush, deferring it until that entry lands.
    assign flush = ended_seen_q && !in_rd_ready && !pending_q &&
                   (fill_cnt < PACK_FULL);

    pack_line_buf #(
        .SLOT_W    (E),
        .PACK_N    (PACK_N),
        .BITS_PACK (BITS_PACK)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (capture),
        .wr_data_i   (in_slot),
        .clr_i       (handshake),
        .fill_cnt_o  (fill_cnt),
        .line_data_o (line_data),
        .line_mask_o (line_mask)
    );

    // Next-state logic for the FSM, counters and the row-order check.
    always_comb begin
        state_d      = state_q;
        line_last_d  = line_last_q;
        pending_d    = rd_en;
        ended_seen_d = ended_seen_q | data_ended;
        prev_row_d   = prev_row_q;
        prev_valid_d = prev_valid_q;
        entry_cnt_d  = entry_cnt_q;
        err_order_d  = err_order_q;

        if (capture) begin
            prev_row_d   = in_row;
            prev_valid_d = 1'b1;
            entry_cnt_d  = entry_cnt_q + BITS_CNT'(1);
            if (prev_valid_q && (in_row <= prev_row_q)) begin
                err_order_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (en_global) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (line_full) begin
                    state_d     = EMIT;
                    line_last_d = 1'b0;
                end else if (flush) begin
                    state_d     = EMIT;
                    line_last_d = 1'b1;
                end
            end
            EMIT: begin
                if (handshake) begin
                    state_d     = line_last_q ? DONE : FILL;
                    line_last_d = 1'b0;
                end
            end
            default: begin
                state_d = DONE;
            end
        endcase

        line_valid_d = (state_d == EMIT);
        done_d       = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            ended_seen_q <= 1'b0;
            prev_row_q   <= '0;
            prev_valid_q <= 1'b0;
            entry_cnt_q  <= '0;
            err_order_q  <= 1'b0;
            line_valid_q <= 1'b0;
            line_last_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            ended_seen_q <= ended_seen_d;
            prev_row_q   <= prev_row_d;
            prev_valid_q <= prev_valid_d;
            entry_cnt_q  <= entry_cnt_d;
            err_order_q  <= err_order_d;
            line_valid_q <= line_valid_d;
            line_last_q  <= line_last_d;
            done_q       <= done_d;
        end
    end

    assign in_rd_en   = rd_en;
    assign line_valid = line_valid_q;
    assign line_last  = line_last_q;
    assign entry_cnt  = entry_cnt_q;
    assign err_order  = err_order_q;
    assign done       = done_q;
    assign state_dbg  = state_q;

endmodule
